// File: rtl/dual_rail_rx.sv
// Four-phase dual-rail bit receiver: classifies rail pairs, filters glitches with a run counter,
// delivers accepted bits over valid/ready and counts protocol errors. Define DUAL_RAIL_RX_SYNC_EN
// to pass both rails through 2-flop synchronizers before classification.
module dual_rail_rx #(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             rail_t,
    input  logic             rail_f,
    input  logic             ready,
    input  logic             err_clr,
    output logic             valid,
    output logic             data,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        C_SPACER  = 2'b00,
        C_ZERO    = 2'b01,
        C_ONE     = 2'b10,
        C_ILLEGAL = 2'b11
    } code_t;

    typedef enum logic [1:0] {
        S_WAIT_SPACER,
        S_ARMED,
        S_HELD
    } state_t;

    logic t_s;
    logic f_s;

`ifdef DUAL_RAIL_RX_SYNC_EN
    logic [1:0] t_sync;
    logic [1:0] f_sync;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            t_sync <= '0;
            f_sync <= '0;
        end else begin
            t_sync <= {t_sync[0], rail_t};
            f_sync <= {f_sync[0], rail_f};
        end
    end

    assign t_s = t_sync[1];
    assign f_s = f_sync[1];
`else
    assign t_s = rail_t;
    assign f_s = rail_f;
`endif

    code_t            code;
    code_t            code_q;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_d;
    logic             stable;
    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             ill_err;
    logic             ovr_err;
    logic             load;
    logic [1:0]       code_err;

    // stable is an event: it fires only on the edge the run count first reaches the limit,
    // so a long-held code (including 11) acts exactly once.
    always_comb begin
        code = code_t'({t_s, f_s});
        if (code == code_q && run_q != '0)
            run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + CNT_W'(1);
        else
            run_d = CNT_W'(1);
        stable = (run_d == RUN_MAX) && (run_q != RUN_MAX || code != code_q);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            code_q  <= C_SPACER;
            run_q   <= '0;
            state_q <= S_WAIT_SPACER;
        end else begin
            code_q  <= code;
            run_q   <= run_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stable) begin
            if (code == C_ILLEGAL) begin
                state_d = S_WAIT_SPACER;
            end else begin
                case (state_q)
                    S_WAIT_SPACER: if (code == C_SPACER) state_d = S_ARMED;
                    S_ARMED:       if (code == C_ONE || code == C_ZERO) state_d = S_HELD;
                    S_HELD:        if (code == C_SPACER) state_d = S_ARMED;
                    default:       state_d = S_WAIT_SPACER;
                endcase
            end
        end
    end

    always_comb begin
        accept   = stable && (state_q == S_ARMED) && (code == C_ONE || code == C_ZERO);
        ill_err  = stable && (code == C_ILLEGAL);
        ovr_err  = accept && valid && !ready;
        load     = accept && !ovr_err;
        code_err = ill_err ? 2'b01 : (ovr_err ? 2'b10 : 2'b00);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            valid     <= 1'b0;
            data      <= 1'b0;
            err_pulse <= 1'b0;
            err_code  <= 2'b00;
            err_count <= '0;
        end else begin
            err_pulse <= ill_err || ovr_err;
            err_code  <= code_err;
            if (load) begin
                data  <= (code == C_ONE);
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (err_clr)
                err_count <= '0;
            else if ((ill_err || ovr_err) && err_count != '1)
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_dual_rail_rx.sv
// Self-checking bench for dual_rail_rx: directed rail sequences with a queue scoreboard of
// expected accepted bits and error codes, plus point checks of handshake and counter state.
module tb_dual_rail_rx;

    localparam int S = 3;
`ifdef DUAL_RAIL_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       areset_n;
    logic       rail_t;
    logic       rail_f;
    logic       ready;
    logic       err_clr;
    logic       valid;
    logic       data;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] err_count;
    logic       w2_valid;
    logic       w2_data;
    logic       w2_err_pulse;
    logic [1:0] w2_err_code;
    logic [1:0] w2_err_count;

    int n_vec = 0;
    int n_err = 0;
    logic       exp_bits[$];
    logic [1:0] exp_errs[$];
    logic       valid_prev = 1'b0;

    dual_rail_rx #(.STABLE_CYCLES(S), .ERR_W(8)) u_dut (
        .clk(clk), .areset_n(areset_n), .rail_t(rail_t), .rail_f(rail_f),
        .ready(ready), .err_clr(err_clr), .valid(valid), .data(data),
        .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count)
    );

    dual_rail_rx #(.STABLE_CYCLES(S), .ERR_W(2)) u_dut_w2 (
        .clk(clk), .areset_n(areset_n), .rail_t(rail_t), .rail_f(rail_f),
        .ready(ready), .err_clr(err_clr), .valid(w2_valid), .data(w2_data),
        .err_pulse(w2_err_pulse), .err_code(w2_err_code), .err_count(w2_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic hold(input logic t, input logic f, input int n);
        for (int i = 0; i < n; i++) begin
            rail_t = t;
            rail_f = f;
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every new bit and every error pulse must match the head of its queue
    always @(posedge clk) begin
        #1;
        if (areset_n) begin
            if (valid && !valid_prev) begin
                if (exp_bits.size() == 0) chk("unexp_valid", 32'(valid), 32'(0));
                else chk("sb_bit", 32'(data), 32'(exp_bits.pop_front()));
            end
            if (err_pulse) begin
                if (exp_errs.size() == 0) chk("unexp_err", 32'(err_pulse), 32'(0));
                else chk("sb_err", 32'(err_code), 32'(exp_errs.pop_front()));
            end
        end
        valid_prev = valid;
    end

    initial begin
        areset_n = 1'b0;
        rail_t   = 1'b0;
        rail_f   = 1'b0;
        ready    = 1'b1;
        err_clr  = 1'b0;
        #23;
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_data", 32'(data), 32'(0));
        chk("rst_pulse", 32'(err_pulse), 32'(0));
        chk("rst_code", 32'(err_code), 32'(0));
        chk("rst_count", 32'(err_count), 32'(0));
        @(posedge clk);
        #1;
        areset_n = 1'b1;

        // basic acceptance
        hold(1'b0, 1'b0, S);
        hold(1'b1, 1'b0, S - 1 + LAT);
        chk("basic_early", 32'(valid), 32'(0));
        exp_bits.push_back(1'b1);
        hold(1'b1, 1'b0, 1);
        chk("basic_valid", 32'(valid), 32'(1));
        chk("basic_data", 32'(data), 32'(1));
        hold(1'b1, 1'b0, 1);
        chk("basic_drop", 32'(valid), 32'(0));
        chk("basic_hold", 32'(data), 32'(1));
        hold(1'b0, 1'b0, S + LAT);

        // glitch rejection
        hold(1'b0, 1'b1, S - 1);
        hold(1'b0, 1'b0, S + LAT + 1);
        chk("glitch_valid", 32'(valid), 32'(0));
        chk("glitch_count", 32'(err_count), 32'(0));

        // overrun
        ready = 1'b0;
        exp_bits.push_back(1'b0);
        hold(1'b0, 1'b1, S + LAT);
        chk("ovr_v0", 32'(valid), 32'(1));
        chk("ovr_d0", 32'(data), 32'(0));
        hold(1'b0, 1'b0, S + LAT);
        exp_errs.push_back(2'b10);
        hold(1'b1, 1'b0, S + LAT);
        chk("ovr_data", 32'(data), 32'(0));
        chk("ovr_valid", 32'(valid), 32'(1));
        chk("ovr_pulse", 32'(err_pulse), 32'(1));
        chk("ovr_code", 32'(err_code), 32'(2'b10));
        chk("ovr_count", 32'(err_count), 32'(1));
        ready = 1'b1;
        hold(1'b1, 1'b0, 1);
        chk("ovr_drain", 32'(valid), 32'(0));
        chk("ovr_pulse_end", 32'(err_pulse), 32'(0));
        hold(1'b0, 1'b0, S + LAT);

        // illegal code
        exp_errs.push_back(2'b01);
        hold(1'b1, 1'b1, S + LAT);
        chk("ill_pulse", 32'(err_pulse), 32'(1));
        chk("ill_code", 32'(err_code), 32'(2'b01));
        chk("ill_count", 32'(err_count), 32'(2));
        hold(1'b1, 1'b1, 2);
        chk("ill_once", 32'(err_pulse), 32'(0));
        hold(1'b1, 1'b0, S + LAT + 2);
        chk("ill_ignore", 32'(valid), 32'(0));
        hold(1'b0, 1'b0, S + LAT);
        exp_bits.push_back(1'b1);
        hold(1'b1, 1'b0, S + LAT);
        chk("ill_recover", 32'(valid), 32'(1));
        chk("ill_rec_data", 32'(data), 32'(1));
        hold(1'b0, 1'b0, S + LAT);

        // counter saturation and clear
        for (int e = 0; e < 5; e++) begin
            exp_errs.push_back(2'b01);
            hold(1'b1, 1'b1, S + LAT);
            hold(1'b0, 1'b0, S + LAT);
        end
        chk("sat_w2", 32'(w2_err_count), 32'(3));
        chk("sat_w8", 32'(err_count), 32'(7));
        exp_errs.push_back(2'b01);
        hold(1'b1, 1'b1, S + LAT - 1);
        err_clr = 1'b1;
        hold(1'b1, 1'b1, 1);
        err_clr = 1'b0;
        chk("clr_pulse", 32'(w2_err_pulse), 32'(1));
        chk("clr_w2", 32'(w2_err_count), 32'(0));
        chk("clr_w8", 32'(err_count), 32'(0));
        hold(1'b1, 1'b1, 1);
        chk("clr_stay", 32'(err_count), 32'(0));
        hold(1'b0, 1'b0, S + LAT);

        // mid-operation reset
        ready = 1'b0;
        exp_bits.push_back(1'b1);
        hold(1'b1, 1'b0, S + LAT);
        chk("mrst_pre", 32'(valid), 32'(1));
        areset_n = 1'b0;
        #2;
        chk("mrst_valid", 32'(valid), 32'(0));
        chk("mrst_data", 32'(data), 32'(0));
        chk("mrst_pulse", 32'(err_pulse), 32'(0));
        chk("mrst_code", 32'(err_code), 32'(0));
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        ready = 1'b1;
        hold(1'b1, 1'b0, 5 + LAT);
        chk("mrst_novalid", 32'(valid), 32'(0));
        hold(1'b0, 1'b0, S + LAT);
        exp_bits.push_back(1'b0);
        hold(1'b0, 1'b1, S + LAT);
        chk("mrst_valid2", 32'(valid), 32'(1));
        chk("mrst_data2", 32'(data), 32'(0));
        hold(1'b0, 1'b0, S + LAT);

        chk("sb_bits_left", 32'(exp_bits.size()), 32'(0));
        chk("sb_errs_left", 32'(exp_errs.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
